// File: rtl/wait_mask_pkg.sv
// Shared definitions for the per-core thread wait-mask tracker:
// stall-source bit positions, the default trace-entry layout and the
// drop-counter width.
package wait_mask_pkg;

    // Stall source indices within one thread's NUM_SRC-bit group
    localparam int WM_SRC_IMISS    = 0;
    localparam int WM_SRC_OTHER    = 1;
    localparam int WM_SRC_STBWAIT  = 2;
    localparam int WM_SRC_MUL_WAIT = 3;
    localparam int WM_SRC_DIV_WAIT = 4;
    localparam int WM_SRC_FP_WAIT  = 5;
    localparam int WM_SRC_MUL_BUSY = 6;
    localparam int WM_SRC_DIV_BUSY = 7;
    localparam int WM_SRC_FP_BUSY  = 8;
    localparam int WM_SRC_LDMISS   = 9;

    // Default configuration of the tracker
    localparam int WM_DEF_NUM_THR = 4;
    localparam int WM_DEF_NUM_SRC = 10;
    localparam int WM_DEF_TS_W    = 32;

    // Width of the saturating lost-event counter
    localparam int DROP_CNT_W = 16;

    // Trace entry for the default configuration; the tracker builds a
    // width-matched local copy of the same layout from its parameters.
    typedef struct packed {
        logic [WM_DEF_TS_W-1:0]                   ts;
        logic [WM_DEF_NUM_SRC*WM_DEF_NUM_THR-1:0] mask;
    } wm_entry_t;

endpackage

// File: rtl/wm_trace_fifo.sv
// Synchronous trace FIFO with a registered head-of-queue output.
// The output register always holds the oldest entry while valid, so the
// consumer sees stable data until it pops. A push into a full FIFO is
// accepted when a pop happens on the same edge.
module wm_trace_fifo #(
    parameter int W     = 72,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic         valid,
    output logic [W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR    = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [W-1:0]  dout_reg;
    logic          valid_reg;
    logic          rd_en;
    logic          wr_en;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign rd_en = pop && !empty;
    // Full FIFO still takes a push when the head leaves on the same edge
    assign wr_en = push && (!full || rd_en);
    assign valid = valid_reg;
    assign dout  = dout_reg;

    // Next read pointer and occupancy
    always_comb begin
        rd_ptr_next = rd_en ? (rd_ptr_reg + ONE_PTR) : rd_ptr_reg;
        count_next  = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + ONE_COUNT;
            2'b01:   count_next = count_reg - ONE_COUNT;
            default: count_next = count_reg;
        endcase
    end

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers, occupancy and the registered head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            dout_reg   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= (count_next != '0);
            // New entry becomes the head only when nothing older remains
            if (wr_en && (count_reg == (rd_en ? ONE_COUNT : '0))) begin
                dout_reg <= din;
            end else if (rd_en) begin
                dout_reg <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/wait_mask_tracker.sv
// Per-core thread wait-mask tracker. Samples the stall-reason vector,
// queues timestamped change events in a trace FIFO, counts lost events
// and keeps saturating per-bit stall-cycle counters.
// Optional macro WAIT_MASK_TRACKER_DISPLAY_EN adds console printing of
// every accepted or dropped push; logic and ports are unchanged by it.
module wait_mask_tracker
    import wait_mask_pkg::*;
#(
    parameter int NUM_THR    = WM_DEF_NUM_THR,
    parameter int NUM_SRC    = WM_DEF_NUM_SRC,
    parameter int CNT_W      = 32,
    parameter int TS_W       = WM_DEF_TS_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [NUM_SRC*NUM_THR-1:0]            wm_vec,
    input  logic [9:0]                            coreid,
    output logic                                  evt_valid,
    input  logic                                  evt_ready,
    output logic [NUM_SRC*NUM_THR-1:0]            evt_mask,
    output logic [TS_W-1:0]                       evt_ts,
    output logic [DROP_CNT_W-1:0]                 drop_cnt,
    input  logic [$clog2(NUM_SRC*NUM_THR)-1:0]    cnt_sel,
    output logic [CNT_W-1:0]                      cnt_val,
    input  logic                                  clr_cnt
);

    localparam int NUM   = NUM_SRC * NUM_THR;
    localparam int SEL_W = $clog2(NUM);
    localparam logic [SEL_W:0]      NUM_EXT  = (SEL_W+1)'(NUM);
    localparam logic [TS_W-1:0]     TS_ONE   = TS_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [NUM-1:0]  mask;
    } entry_t;

    logic [TS_W-1:0]       ts_reg;
    logic [NUM-1:0]        prev_reg;
    logic                  push_reg;
    entry_t                entry_reg;
    entry_t                fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_valid;
    logic                  pop;
    logic                  drop;
    logic                  change;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0]      cnt_bus [NUM];
    logic [CNT_W-1:0]      cnt_val_reg;
    logic                  unused_sig;

    assign change = en && (wm_vec != prev_reg);
    assign pop    = fifo_valid && evt_ready;
    // A registered push that meets a full FIFO with no pop is lost
    assign drop   = push_reg && fifo_full && !pop;

    // Timestamp, change detection and the one-entry push stage
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_reg    <= '0;
            prev_reg  <= '0;
            push_reg  <= 1'b0;
            entry_reg <= '0;
        end else begin
            ts_reg   <= ts_reg + TS_ONE;
            push_reg <= change;
            if (en) begin
                prev_reg <= wm_vec;
            end
            if (change) begin
                entry_reg.ts   <= ts_reg;
                entry_reg.mask <= wm_vec;
            end
        end
    end

    wm_trace_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_reg),
        .din   (entry_reg),
        .pop   (evt_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .valid (fifo_valid),
        .dout  (fifo_dout)
    );

    // Saturating count of events lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_reg <= drop_cnt_reg + DROP_ONE;
        end
    end

    // One saturating stall-cycle counter per wait-mask bit
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;

            // Clear wins over a same-cycle increment
            always_ff @(posedge clk) begin
                if (rst || clr_cnt) begin
                    count_reg <= '0;
                end else if (en && wm_vec[gi] && (count_reg != '1)) begin
                    count_reg <= count_reg + CNT_ONE;
                end
            end

            assign cnt_bus[gi] = count_reg;
        end
    endgenerate

    // Registered counter readback, zero for indices past the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_val_reg <= '0;
        end else if ({1'b0, cnt_sel} < NUM_EXT) begin
            cnt_val_reg <= cnt_bus[cnt_sel];
        end else begin
            cnt_val_reg <= '0;
        end
    end

    assign evt_valid  = fifo_valid;
    assign evt_mask   = fifo_dout.mask;
    assign evt_ts     = fifo_dout.ts;
    assign drop_cnt   = drop_cnt_reg;
    assign cnt_val    = cnt_val_reg;
    assign unused_sig = ^{coreid, fifo_empty};

`ifdef WAIT_MASK_TRACKER_DISPLAY_EN
    // Console trace of each push as it reaches the FIFO
    always_ff @(posedge clk) begin
        if (!rst && push_reg) begin
            if (drop) begin
                $display("%d: C%1d: WM DROP", $time, coreid);
            end else begin
                $display("%d: C%1d: WM: %x", $time, coreid, entry_reg.mask);
            end
        end
    end
`endif

endmodule

// File: tb/tb_wait_mask_tracker.sv
// Directed bench for wait_mask_tracker: reset state, first-event latency
// and timestamp, FIFO overflow with drop counting, push/pop on a full
// FIFO, counter saturation/clear/hold, and reset with queued entries.
module tb_wait_mask_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [39:0] wm_vec;
    logic [9:0]  coreid;
    logic        evt_ready;
    logic [5:0]  cnt_sel;
    logic        clr_cnt;

    logic        evt_valid;
    logic [39:0] evt_mask;
    logic [31:0] evt_ts;
    logic [15:0] drop_cnt;
    logic [31:0] cnt_val;

    logic        evt_valid4;
    logic [39:0] evt_mask4;
    logic [31:0] evt_ts4;
    logic [15:0] drop_cnt4;
    logic [3:0]  cnt_val4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wait_mask_tracker dut (
        .clk(clk), .rst(rst), .en(en), .wm_vec(wm_vec), .coreid(coreid),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_mask(evt_mask),
        .evt_ts(evt_ts), .drop_cnt(drop_cnt), .cnt_sel(cnt_sel),
        .cnt_val(cnt_val), .clr_cnt(clr_cnt)
    );

    wait_mask_tracker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .wm_vec(wm_vec), .coreid(coreid),
        .evt_valid(evt_valid4), .evt_ready(evt_ready), .evt_mask(evt_mask4),
        .evt_ts(evt_ts4), .drop_cnt(drop_cnt4), .cnt_sel(cnt_sel),
        .cnt_val(cnt_val4), .clr_cnt(clr_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b1; wm_vec = '0; evt_ready = 1'b0;
        clr_cnt = 1'b0; cnt_sel = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", evt_valid); end
        n_cmp++; if (evt_mask !== 40'h0) begin n_bad++; $display("FAIL reset_mask got %h want 0", evt_mask); end
        n_cmp++; if (evt_ts !== 32'h0) begin n_bad++; $display("FAIL reset_ts got %0d want 0", evt_ts); end
        n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        n_cmp++; if (cnt_val !== 32'h0) begin n_bad++; $display("FAIL reset_cnt_val got %0d want 0", cnt_val); end
        n_cmp++; if ({evt_valid4, evt_mask4, evt_ts4, drop_cnt4, cnt_val4} !== '0) begin
            n_bad++; $display("FAIL reset_dut4 got %0b/%h/%0d/%0d/%0d want all 0",
                              evt_valid4, evt_mask4, evt_ts4, drop_cnt4, cnt_val4);
        end
        repeat (20) step();
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %0b want 0", evt_valid); end
        n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL idle_drop got %0d want 0", drop_cnt); end
        for (int i = 0; i < 40; i++) begin
            cnt_sel = 6'(i);
            step();
            n_cmp++; if (cnt_val !== 32'h0) begin n_bad++; $display("FAIL idle_cnt[%0d] got %0d want 0", i, cnt_val); end
        end
        $display("test_reset done");
    endtask

    task automatic test_first_event();
        apply_reset();
        repeat (5) step();
        wm_vec = 40'h1; evt_ready = 1'b1; cnt_sel = 6'd0;
        step();
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL first_latency got %0b want 0", evt_valid); end
        step();
        n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %0b want 1", evt_valid); end
        n_cmp++; if (evt_mask !== 40'h1) begin n_bad++; $display("FAIL first_mask got %h want 1", evt_mask); end
        n_cmp++; if (evt_ts !== 32'd5) begin n_bad++; $display("FAIL first_ts got %0d want 5", evt_ts); end
        $display("pop mask=%h ts=%0d", evt_mask, evt_ts);
        step();
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL first_popped got %0b want 0", evt_valid); end
        repeat (7) step();
        wm_vec = 40'h0;
        step();
        n_cmp++; if (cnt_val !== 32'd10) begin n_bad++; $display("FAIL cnt0_hold10 got %0d want 10", cnt_val); end
        cnt_sel = 6'd1;
        step();
        n_cmp++; if (cnt_val !== 32'd0) begin n_bad++; $display("FAIL cnt1 got %0d want 0", cnt_val); end
        cnt_sel = 6'd63;
        step();
        n_cmp++; if (cnt_val !== 32'd0) begin n_bad++; $display("FAIL cnt_out_of_range got %0d want 0", cnt_val); end
        $display("test_first_event done");
    endtask

    task automatic test_overflow();
        logic [39:0] exp_mask;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            wm_vec = 40'(i + 1);
            step();
        end
        repeat (2) step();
        n_cmp++; if (drop_cnt !== 16'd4) begin n_bad++; $display("FAIL ovf_drop got %0d want 4", drop_cnt); end
        n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got %0b want 1", evt_valid); end
        evt_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            exp_mask = 40'(j + 1);
            n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_pop%0d_valid got %0b want 1", j, evt_valid); end
            n_cmp++; if (evt_mask !== exp_mask) begin n_bad++; $display("FAIL ovf_pop%0d_mask got %h want %h", j, evt_mask, exp_mask); end
            n_cmp++; if (evt_ts !== 32'(j)) begin n_bad++; $display("FAIL ovf_pop%0d_ts got %0d want %0d", j, evt_ts, j); end
            $display("pop mask=%h ts=%0d", evt_mask, evt_ts);
            step();
        end
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained got %0b want 0", evt_valid); end
        n_cmp++; if (drop_cnt !== 16'd4) begin n_bad++; $display("FAIL ovf_drop_after got %0d want 4", drop_cnt); end
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp_mask;
        logic [31:0] exp_ts;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            wm_vec = 40'(i + 1);
            step();
        end
        step();
        n_cmp++; if (evt_mask !== 40'h1) begin n_bad++; $display("FAIL b2b_full_head got %h want 1", evt_mask); end
        wm_vec = 40'd9;
        step();
        n_cmp++; if (evt_mask !== 40'h1) begin n_bad++; $display("FAIL b2b_stable_head got %h want 1", evt_mask); end
        evt_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            exp_mask = 40'(j + 1);
            exp_ts   = (j < 8) ? 32'(j) : 32'd9;
            n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_pop%0d_valid got %0b want 1", j, evt_valid); end
            n_cmp++; if (evt_mask !== exp_mask) begin n_bad++; $display("FAIL b2b_pop%0d_mask got %h want %h", j, evt_mask, exp_mask); end
            n_cmp++; if (evt_ts !== exp_ts) begin n_bad++; $display("FAIL b2b_pop%0d_ts got %0d want %0d", j, evt_ts, exp_ts); end
            $display("pop mask=%h ts=%0d", evt_mask, evt_ts);
            step();
        end
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained got %0b want 0", evt_valid); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL b2b_drop got %0d want 0", drop_cnt); end
        $display("test_back_to_back done");
    endtask

    task automatic test_counter_sat();
        apply_reset();
        wm_vec = 40'h1; cnt_sel = 6'd0; evt_ready = 1'b1;
        repeat (21) step();
        n_cmp++; if (cnt_val4 !== 4'hF) begin n_bad++; $display("FAIL sat4 got %h want f", cnt_val4); end
        n_cmp++; if (cnt_val !== 32'd20) begin n_bad++; $display("FAIL cnt32_20 got %0d want 20", cnt_val); end
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        step();
        n_cmp++; if (cnt_val4 !== 4'h0) begin n_bad++; $display("FAIL clr4 got %h want 0", cnt_val4); end
        n_cmp++; if (cnt_val !== 32'd0) begin n_bad++; $display("FAIL clr32 got %0d want 0", cnt_val); end
        step();
        n_cmp++; if (cnt_val4 !== 4'h1) begin n_bad++; $display("FAIL after_clr4 got %h want 1", cnt_val4); end
        n_cmp++; if (cnt_val !== 32'd1) begin n_bad++; $display("FAIL after_clr32 got %0d want 1", cnt_val); end
        en = 1'b0;
        repeat (2) step();
        n_cmp++; if (cnt_val !== 32'd2) begin n_bad++; $display("FAIL en_hold got %0d want 2", cnt_val); end
        n_cmp++; if (cnt_val4 !== 4'h2) begin n_bad++; $display("FAIL en_hold4 got %h want 2", cnt_val4); end
        en = 1'b1;
        $display("test_counter_sat done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            wm_vec = 40'(i + 1);
            step();
        end
        step();
        n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL mid_queued got %0b want 1", evt_valid); end
        rst = 1'b1;
        step();
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %0b want 0", evt_valid); end
        n_cmp++; if (evt_mask !== 40'h0) begin n_bad++; $display("FAIL mid_rst_mask got %h want 0", evt_mask); end
        n_cmp++; if (evt_ts !== 32'h0) begin n_bad++; $display("FAIL mid_rst_ts got %0d want 0", evt_ts); end
        rst = 1'b0;
        wm_vec = 40'd5;
        repeat (2) step();
        n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL mid_new_valid got %0b want 1", evt_valid); end
        n_cmp++; if (evt_mask !== 40'd5) begin n_bad++; $display("FAIL mid_new_mask got %h want 5", evt_mask); end
        n_cmp++; if (evt_ts !== 32'd0) begin n_bad++; $display("FAIL mid_new_ts got %0d want 0", evt_ts); end
        $display("pop mask=%h ts=%0d", evt_mask, evt_ts);
        evt_ready = 1'b1;
        step();
        n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL mid_only_one got %0b want 0", evt_valid); end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wm_vec = '0; coreid = 10'd3;
        evt_ready = 1'b0; cnt_sel = '0; clr_cnt = 1'b0;
        test_reset();
        test_first_event();
        test_overflow();
        test_back_to_back();
        test_counter_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
